// File: rtl/mic_array_pkg.sv
// Shared constants and frame type for the microphone-array capture path.
// Everything downstream of the MEMS driver agrees on these widths.
package mic_array_pkg;

    localparam int MIC_DATA_W = 24;
    localparam int MIC_NUM_CH = 6;
    localparam int MIC_CHAN_W = 3;

    localparam logic [MIC_CHAN_W-1:0] MIC_CHAN_LAST = MIC_CHAN_W'(MIC_NUM_CH - 1);

    typedef logic [MIC_NUM_CH-1:0][MIC_DATA_W-1:0] mic_frame_t;

    // Advance a channel index, wrapping after the last channel.
    function automatic logic [MIC_CHAN_W-1:0] mic_next_chan(input logic [MIC_CHAN_W-1:0] chan);
        return (chan == MIC_CHAN_LAST) ? '0 : chan + MIC_CHAN_W'(1);
    endfunction

endpackage

// File: rtl/mic_frame_slot.sv
// One frame register bank: captures a whole frame on we_i and presents the
// channel picked by sel_i combinationally.
module mic_frame_slot
    import mic_array_pkg::*;
(
    input  logic                  clk,
    input  logic                  we_i,
    input  mic_frame_t            frame_i,
    input  logic [MIC_CHAN_W-1:0] sel_i,
    output logic [MIC_DATA_W-1:0] rd_data_o
);

    mic_frame_t frame_q;

    // Contents are don't-care after reset; the consumer only looks while valid.
    always_ff @(posedge clk) begin
        if (we_i) begin
            frame_q <= frame_i;
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int c = 0; c < MIC_NUM_CH; c++) begin
            if (sel_i == c[MIC_CHAN_W-1:0]) begin
                rd_data_o = frame_q[c];
            end
        end
    end

endmodule

// File: rtl/mic_frame_serializer.sv
// Captures 6-channel mic frames into a 2-slot ping-pong buffer and replays
// them as a channel-tagged valid/ready word stream, counting dropped frames.
module mic_frame_serializer
    import mic_array_pkg::*;
#(
    parameter int DATA_W = MIC_DATA_W,
    parameter int NUM_CH = MIC_NUM_CH,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mic0_data_i,
    input  logic [DATA_W-1:0] mic1_data_i,
    input  logic [DATA_W-1:0] mic2_data_i,
    input  logic [DATA_W-1:0] mic3_data_i,
    input  logic [DATA_W-1:0] mic4_data_i,
    input  logic [DATA_W-1:0] mic5_data_i,
    input  logic              mic_data_vld_i,
    output logic [DATA_W-1:0] m_data,
    output logic [2:0]        m_chan,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              overflow_o,
    output logic [DROP_W-1:0] drop_cnt_o,
    input  logic              clr_stat_i
);

    localparam int NUM_SLOTS = 2;

    logic [1:0]            count_q, count_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [MIC_CHAN_W-1:0] chan_q, chan_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_W-1:0]     drop_cnt_q, drop_cnt_d;

    logic                  xfer;
    logic                  last_xfer;
    logic                  slot_free;
    logic                  wr_en;
    logic                  drop;
    mic_frame_t            frame_in;
    logic [NUM_SLOTS-1:0][MIC_DATA_W-1:0] slot_rd;

    assign frame_in = {mic5_data_i, mic4_data_i, mic3_data_i,
                       mic2_data_i, mic1_data_i, mic0_data_i};

    // Handshake and slot-availability decode.
    always_comb begin
        xfer      = m_valid && m_ready;
        last_xfer = xfer && (chan_q == MIC_CHAN_LAST);
        // A full buffer still accepts a frame when the read slot empties this cycle.
        slot_free = (count_q < 2'd2) || last_xfer;
        wr_en     = mic_data_vld_i && slot_free;
        drop      = mic_data_vld_i && !slot_free;
    end

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        mic_frame_slot u_slot (
            .clk      (clk),
            .we_i     (wr_en && (wr_ptr_q == s[0])),
            .frame_i  (frame_in),
            .sel_i    (chan_q),
            .rd_data_o(slot_rd[s])
        );
    end

    // Next-state for pointers, occupancy and read channel.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        chan_d   = chan_q;
        count_d  = count_q;

        if (wr_en) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (xfer) begin
            chan_d = mic_next_chan(chan_q);
        end
        if (last_xfer) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        if (wr_en && !last_xfer) begin
            count_d = count_q + 2'd1;
        end else if (!wr_en && last_xfer) begin
            count_d = count_q - 2'd1;
        end
    end

    // A drop in the same cycle as a clear wins and restarts the count at one.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_stat_i) begin
                drop_cnt_d = DROP_W'(1);
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end else if (clr_stat_i) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            chan_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            chan_q     <= chan_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Data is forced to zero when idle so stale or unreset storage never leaks out.
    always_comb begin
        m_valid    = (count_q != 2'd0);
        m_chan     = chan_q;
        m_last     = m_valid && (chan_q == MIC_CHAN_LAST);
        m_data     = m_valid ? DATA_W'(slot_rd[rd_ptr_q]) : '0;
        overflow_o = overflow_q;
        drop_cnt_o = drop_cnt_q;
    end

endmodule

// File: tb/tb_mic_frame_serializer.sv
// Directed bench: a frame-queue model checks every cycle, and literal
// expectations at key points pin both the model and the design.
module tb_mic_frame_serializer;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0][DW-1:0] mic_in;
    logic          vld;
    logic          rdy;
    logic          clr;

    logic [DW-1:0] m_data,  m_data2;
    logic [2:0]    m_chan,  m_chan2;
    logic          m_last,  m_last2;
    logic          m_valid, m_valid2;
    logic          ovf,     ovf2;
    logic [15:0]   drop;
    logic [1:0]    drop2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mic_frame_serializer #(.DATA_W(24), .NUM_CH(6), .DROP_W(16)) dut (
        .clk(clk), .rst(rst),
        .mic0_data_i(mic_in[0]), .mic1_data_i(mic_in[1]), .mic2_data_i(mic_in[2]),
        .mic3_data_i(mic_in[3]), .mic4_data_i(mic_in[4]), .mic5_data_i(mic_in[5]),
        .mic_data_vld_i(vld),
        .m_data(m_data), .m_chan(m_chan), .m_last(m_last), .m_valid(m_valid),
        .m_ready(rdy), .overflow_o(ovf), .drop_cnt_o(drop), .clr_stat_i(clr)
    );

    mic_frame_serializer #(.DATA_W(24), .NUM_CH(6), .DROP_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .mic0_data_i(mic_in[0]), .mic1_data_i(mic_in[1]), .mic2_data_i(mic_in[2]),
        .mic3_data_i(mic_in[3]), .mic4_data_i(mic_in[4]), .mic5_data_i(mic_in[5]),
        .mic_data_vld_i(vld),
        .m_data(m_data2), .m_chan(m_chan2), .m_last(m_last2), .m_valid(m_valid2),
        .m_ready(rdy), .overflow_o(ovf2), .drop_cnt_o(drop2), .clr_stat_i(clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef logic [5:0][DW-1:0] frm_t;
    frm_t mq[$];
    int   mchan = 0;
    bit   movf  = 0;
    int   mdrop = 0;
    int   mdrop2 = 0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mchan  = 0;
            movf   = 0;
            mdrop  = 0;
            mdrop2 = 0;
        end else begin
            bit had_room;
            bit frame_done;
            frame_done = (mq.size() > 0) && rdy && (mchan == 5);
            had_room   = (mq.size() < 2) || frame_done;
            if (mq.size() > 0 && rdy) begin
                if (mchan == 5) begin
                    void'(mq.pop_front());
                    mchan = 0;
                end else begin
                    mchan++;
                end
            end
            if (vld) begin
                if (had_room) begin
                    mq.push_back(mic_in);
                end else begin
                    movf   = 1;
                    mdrop  = clr ? 1 : ((mdrop  < 65535) ? mdrop  + 1 : mdrop);
                    mdrop2 = clr ? 1 : ((mdrop2 < 3)     ? mdrop2 + 1 : mdrop2);
                end
            end else if (clr) begin
                movf   = 0;
                mdrop  = 0;
                mdrop2 = 0;
            end
        end
    end

    // Every-cycle comparison against the model, on the falling edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            begin
                bit   ev;
                logic [DW-1:0] ed;
                ev = (mq.size() > 0);
                ed = ev ? mq[0][mchan] : '0;
                chk("m_valid", 32'(m_valid), 32'(ev));
                chk("m_data",  32'(m_data),  32'(ed));
                chk("m_chan",  32'(m_chan),  32'(mchan));
                chk("m_last",  32'(m_last),  32'(ev && mchan == 5));
                chk("overflow", 32'(ovf), 32'(movf));
                chk("drop_cnt", 32'(drop), 32'(mdrop));
                chk("drop_cnt_w2", 32'(drop2), 32'(mdrop2));
                chk("overflow_w2", 32'(ovf2), 32'(movf));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input logic [DW-1:0] base);
        for (int c = 0; c < 6; c++) mic_in[c] = base + DW'(c);
    endtask

    task automatic pulse(input logic [DW-1:0] base);
        set_frame(base);
        vld = 1'b1;
        cyc();
        vld = 1'b0;
        mic_in = '0;
    endtask

    // Expect one frame streamed with m_ready high, words base..base+5.
    task automatic expect_stream(input string name, input logic [DW-1:0] base);
        for (int i = 0; i < 6; i++) begin
            chk({name, "_data"}, 32'(m_data), 32'(base + DW'(i)));
            chk({name, "_chan"}, 32'(m_chan), i);
            chk({name, "_last"}, 32'(m_last), 32'(i == 5));
            cyc();
        end
    endtask

    initial begin
        rst = 1'b1; vld = 1'b0; rdy = 1'b0; clr = 1'b0; mic_in = '0;
        cyc(); cyc();
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_data",  32'(m_data), 0);
        chk("rst_drop",  32'(drop), 0);
        rst = 1'b0;

        // 1: single frame, consumer always ready
        rdy = 1'b1;
        pulse(24'h000001);
        chk("t1_valid", 32'(m_valid), 1);
        expect_stream("t1", 24'h000001);
        chk("t1_idle", 32'(m_valid), 0);

        // 2: stall holds, then one word per ready-high cycle
        rdy = 1'b0;
        pulse(24'h000001);
        for (int i = 0; i < 20; i++) begin
            chk("t2_hold_data", 32'(m_data), 32'h1);
            chk("t2_hold_chan", 32'(m_chan), 0);
            cyc();
        end
        for (int k = 0; k < 6; k++) begin
            rdy = 1'b1; cyc();
            rdy = 1'b0; cyc();
            if (k < 5) begin
                chk("t2_step_chan", 32'(m_chan), k + 1);
                chk("t2_step_data", 32'(m_data), k + 2);
            end
        end
        chk("t2_idle", 32'(m_valid), 0);

        // 3: A and B kept, C dropped
        pulse(24'h000100); cyc();
        pulse(24'h000200); cyc();
        pulse(24'h000300); cyc();
        chk("t3_ovf",  32'(ovf), 1);
        chk("t3_drop", 32'(drop), 1);
        rdy = 1'b1;
        expect_stream("t3a", 24'h000100);
        expect_stream("t3b", 24'h000200);
        chk("t3_idle", 32'(m_valid), 0);

        // 4: new frame lands in the same cycle A's last word leaves
        rdy = 1'b0;
        pulse(24'h000100);
        pulse(24'h000200);
        rdy = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        chk("t4_at_last", 32'(m_last), 1);
        set_frame(24'h000400);
        vld = 1'b1;
        cyc();
        vld = 1'b0;
        chk("t4_drop", 32'(drop), 1);
        expect_stream("t4b", 24'h000200);
        expect_stream("t4d", 24'h000400);
        chk("t4_idle", 32'(m_valid), 0);

        // 5: stats clear, clear-vs-drop collision, saturation of narrow counter
        clr = 1'b1; cyc(); clr = 1'b0;
        chk("t5_clr_ovf",  32'(ovf), 0);
        chk("t5_clr_drop", 32'(drop), 0);
        rdy = 1'b0;
        pulse(24'h000500);
        pulse(24'h000600);
        pulse(24'h000700); // drop -> 1
        clr = 1'b1;
        pulse(24'h000800); // drop with clear -> 1
        clr = 1'b0;
        chk("t5_coll_ovf",  32'(ovf), 1);
        chk("t5_coll_drop", 32'(drop), 1);
        clr = 1'b1; cyc(); clr = 1'b0;
        for (int i = 0; i < 5; i++) pulse(24'h000900);
        chk("t5_drop5",  32'(drop), 5);
        chk("t5_sat_w2", 32'(drop2), 3);
        rdy = 1'b1;
        expect_stream("t5a", 24'h000500);
        expect_stream("t5b", 24'h000600);

        // 6: reset in the middle of a frame
        pulse(24'h000A00);
        cyc(); cyc(); cyc();
        chk("t6_mid_chan", 32'(m_chan), 3);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("t6_valid", 32'(m_valid), 0);
        chk("t6_chan",  32'(m_chan), 0);
        chk("t6_ovf",   32'(ovf), 0);
        pulse(24'h000B00);
        expect_stream("t6", 24'h000B00);
        chk("t6_idle", 32'(m_valid), 0);

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
